// File: rtl/axi_wr_responder_pkg.sv
// Shared constants and types for the AXI single-beat write responder.
// Response codes, default widths and the B-queue entry layout.
package axi_wr_responder_pkg;

   localparam int DEF_ADDR_WIDTH = 64;
   localparam int DEF_DATA_WIDTH = 512;
   localparam int DEF_ID_WIDTH   = 4;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [DEF_ID_WIDTH-1:0] id;
      logic [1:0]              resp;
   } bq_entry_t;

endpackage

// File: rtl/axi_wr_responder_bresp_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and registered storage.
// Writes when full and reads when empty are ignored.
module axi_wr_responder_bresp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wren_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             rden_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push, pop;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   assign push = wren_i & ~full_o;
   assign pop  = rden_i & ~empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/axi_wr_responder.sv
// AXI single-beat write responder: pairs AW and W, pushes {addr, data}
// downstream and returns in-order B responses through a small queue.
module axi_wr_responder
   import axi_wr_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ID_WIDTH   = DEF_ID_WIDTH,
   parameter int BQ_DEPTH   = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [ID_WIDTH-1:0]            awid_i,
   input  logic [ADDR_WIDTH-1:0]          awaddr_i,
   input  logic                           awvalid_i,
   output logic                           awready_o,
   input  logic [ID_WIDTH-1:0]            wid_i,
   input  logic [DATA_WIDTH-1:0]          wdata_i,
   input  logic                           wvalid_i,
   output logic                           wready_o,
   output logic [ID_WIDTH-1:0]            bid_o,
   output logic [1:0]                     bresp_o,
   output logic                           bvalid_o,
   input  logic                           bready_i,
   input  logic                           wrfifo_afull_i,
   output logic                           wrfifo_wren_o,
   output logic [ADDR_WIDTH+DATA_WIDTH-1:0] wrfifo_data_o
);

   typedef struct packed {
      logic [ID_WIDTH-1:0] id;
      logic [1:0]          resp;
   } bq_ent_t;

   logic                  aw_held_q, aw_held_d;
   logic [ID_WIDTH-1:0]   awid_q, awid_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic                  w_held_q, w_held_d;
   logic [ID_WIDTH-1:0]   wid_q, wid_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic    bq_full, bq_empty, commit, id_match;
   bq_ent_t bq_din, bq_head;

   assign awready_o = ~aw_held_q;
   assign wready_o  = ~w_held_q;

   assign id_match = (awid_q == wid_q);
   assign commit   = aw_held_q & w_held_q & ~wrfifo_afull_i & ~bq_full;

   // Mismatched IDs still consume a B slot but never reach the CXL FIFO.
   assign wrfifo_wren_o = commit & id_match;
   assign wrfifo_data_o = {awaddr_q, wdata_q};

   assign bq_din.id   = awid_q;
   assign bq_din.resp = id_match ? AXI_RESP_OKAY : AXI_RESP_SLVERR;

   assign bvalid_o = ~bq_empty;
   assign bid_o    = bq_head.id;
   assign bresp_o  = bq_head.resp;

   always_comb begin
      aw_held_d = aw_held_q;
      awid_d    = awid_q;
      awaddr_d  = awaddr_q;
      w_held_d  = w_held_q;
      wid_d     = wid_q;
      wdata_d   = wdata_q;
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end
      if (awvalid_i && awready_o) begin
         aw_held_d = 1'b1;
         awid_d    = awid_i;
         awaddr_d  = awaddr_i;
      end
      if (wvalid_i && wready_o) begin
         w_held_d = 1'b1;
         wid_d    = wid_i;
         wdata_d  = wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_held_q <= 1'b0;
         awid_q    <= '0;
         awaddr_q  <= '0;
         w_held_q  <= 1'b0;
         wid_q     <= '0;
         wdata_q   <= '0;
      end else begin
         aw_held_q <= aw_held_d;
         awid_q    <= awid_d;
         awaddr_q  <= awaddr_d;
         w_held_q  <= w_held_d;
         wid_q     <= wid_d;
         wdata_q   <= wdata_d;
      end
   end

   axi_wr_responder_bresp_fifo #(
      .DEPTH (BQ_DEPTH),
      .WIDTH (ID_WIDTH + 2)
   ) u_bq (
      .clk     (clk),
      .rst_n   (rst_n),
      .wren_i  (commit),
      .wdata_i (bq_din),
      .rden_i  (bready_i),
      .rdata_o (bq_head),
      .full_o  (bq_full),
      .empty_o (bq_empty)
   );

endmodule

// File: doc/axi_wr_responder.md
Name: axi_wr_responder

Overview:
- AXI single-beat write responder (slave) on the CXL controller side; terminates the AW/W/B traffic issued by the evict write initiator.
- Accepts AW and W independently and pairs them.
- Pushes {addr, data} into the downstream CXL write-request FIFO.
- Returns one B response per paired write, in acceptance order, with the request ID.

Parameters:
- ADDR_WIDTH, 64, AW address width
- DATA_WIDTH, 512, W data width (one beat = one cache block)
- ID_WIDTH, 4, AXI ID width
- BQ_DEPTH, 4, B-response queue depth (max outstanding unacknowledged writes); power of two, >=2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- awid_i  in  ID_WIDTH  write address ID
- awaddr_i  in  ADDR_WIDTH  write address
- awvalid_i  in  1  AW valid
- awready_o  out  1  AW ready
- wid_i  in  ID_WIDTH  write data ID
- wdata_i  in  DATA_WIDTH  write data
- wvalid_i  in  1  W valid
- wready_o  out  1  W ready
- bid_o  out  ID_WIDTH  response ID
- bresp_o  out  2  response code
- bvalid_o  out  1  B valid
- bready_i  in  1  B ready
- wrfifo_afull_i  in  1  downstream write FIFO almost-full
- wrfifo_wren_o  out  1  downstream write enable, one-cycle pulse per write
- wrfifo_data_o  out  ADDR_WIDTH+DATA_WIDTH  {addr, data}; address in the MSBs

Behaviour:
- Reset (async assert, sync release):
  - aw_held=0, w_held=0, BQ empty.
  - awready_o=1, wready_o=1, bvalid_o=0, bid_o=0, bresp_o=0, wrfifo_wren_o=0, wrfifo_data_o=0.
  - Reset mid-transaction discards held AW/W and all queued responses; no B is issued for them.
- AW slot:
  - awready_o = !aw_held.
  - awvalid_i & awready_o at a clock edge captures awid/awaddr and sets aw_held.
- W slot: same rule with wready_o = !w_held, capturing wid/wdata.
- AW and W may arrive in either order or in the same cycle; each slot holds exactly one request.
- commit = aw_held & w_held & !wrfifo_afull_i & !bq_full, where bq_full is the registered full flag.
- On a commit cycle:
  - Both held flags clear at the next edge; readys return the cycle after.
  - Sustained throughput is 1 write per 2 cycles.
  - Enqueue {held_awid, resp} into the BQ.
  - If held_awid == held_wid: resp = OKAY (2'b00); wrfifo_wren_o=1 and wrfifo_data_o={held_awaddr, held_wdata} in the same cycle (combinational from the held registers).
  - If the IDs mismatch: resp = SLVERR (2'b10); wrfifo_wren_o stays 0 and the data is dropped.
- Stall: if wrfifo_afull_i or bq_full is set, no commit occurs. The slots stay held, readys stay low, and nothing is lost.
- B channel:
  - bvalid_o = !bq_empty; bid_o/bresp_o = BQ head.
  - Pop on bvalid_o & bready_i.
  - Head is stable while bvalid_o=1 and bready_i=0 (AXI stability rule).
  - B latency: bvalid_o asserts the cycle after the commit edge, so minimum AW/W-accept to bvalid is 2 cycles.
- BQ:
  - Pointers are log2(BQ_DEPTH)+1 bits with a wrap bit; full/empty are derived from the pointers.
  - Pointers wrap naturally at BQ_DEPTH.
  - Same-cycle push and pop are both performed and the count is unchanged.
  - Push is gated by registered full even when a pop occurs in the same cycle (one-cycle bubble at full, intentional).
- No bursts: every beat is a complete write. There is no wlast and no wstrb; a full-line write is implied.

Decomposition:
- Shared package entries:
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
  - Default ADDR/DATA/ID widths.
  - Packed typedef for the B-queue entry {id, resp}.
- Sub-module bresp_fifo: a generic synchronous FIFO (DEPTH, WIDTH) with full/empty, wren/rden, and registered storage.
- Pairing and commit logic stay in the top module.

Test Plan:
- AW(id=3, addr=0x1000) and W(id=3, data=0xA5..A5) in the same cycle, bready=1:
  - wrfifo_wren_o pulses once with {0x1000, 0xA5..A5}.
  - bvalid with bid=3, bresp=00 two cycles after acceptance.
- W(id=1) accepted 5 cycles before AW(id=1, addr=0x40):
  - wready_o=0 during the gap; single commit once AW arrives; B id=1 OKAY.
- AW id=2 paired with W id=5:
  - No wrfifo_wren_o; B id=2 bresp=10.
- bready_i=0, six back-to-back paired writes:
  - Four commits fill the BQ, then awready/wready stay low.
  - Raising bready_i returns B ids in order, and the remaining two writes commit.
  - bid/bresp stay stable while stalled.
- wrfifo_afull_i=1 with both slots held for 10 cycles:
  - No commit and no B; commit occurs on the cycle afull drops.
- rst_n asserted while 2 B responses are queued and an AW is held:
  - Outputs take reset values immediately (async).
  - After release, no stale B is issued and awready_o=1.
